// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// UART serial receiver. It oversamples the serial line using a
// baud-rate-multiple strobe (bclk), validates the start bit at mid-bit,
// assembles DATA_BITS data bits LSB first and checks a single stop bit.
// The completed byte is placed in the holding register RBR, together with
// a ready flag, a framing-error flag and a sticky overrun flag.
//
// Parameters
//   OVERSAMPLE  bclk ticks per bit period (even, >= 4)
//   DATA_BITS   data bits per frame, also the RBR width (>= 2)
//
// Ports
//   sys_clk      in   system clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   bclk         in   OVERSAMPLE x baud strobe, edge-detected on sys_clk
//   rx_data      in   asynchronous serial line, idle high
//   rx_rd        in   consumer read strobe, acknowledges RBR
//   RBR          out  last completed frame
//   rx_ready     out  RBR holds an unread byte
//   rx_status    out  frame in progress (any state other than IDLE)
//   frame_err    out  stop bit of the last completed frame was low
//   overrun_err  out  an unread RBR was overwritten (sticky until read)
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 rx_data,
  input  logic                 rx_rd,
  output logic [DATA_BITS-1:0] RBR,
  output logic                 rx_ready,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic                 rx_meta_p0;
  logic                 rx_s;
  logic                 bclk_old;
  logic                 tick;
  logic [CW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  // Stage p0/p1: two-flop synchroniser for the asynchronous line. Both
  // flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= rx_data;
      rx_s       <= rx_meta_p0;
    end
  end

  // Rising-edge detect on bclk; tick is high for exactly one sys_clk.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      bclk_old <= 1'b0;
    end else begin
      bclk_old <= bclk;
    end
  end

  assign tick = bclk & ~bclk_old;

  assign rx_status = (state != IDLE);

  // Receive FSM. A read acknowledges RBR first; a frame load in the same
  // cycle is written afterwards so the new byte wins over the read.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      RBR         <= '0;
      rx_ready    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (rx_rd && rx_ready) begin
        rx_ready    <= 1'b0;
        overrun_err <= 1'b0;
      end

      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state      <= START;
              sample_cnt <= '0;
            end
          end

          START: begin
            // Mid-bit check: a start bit that has returned high was a glitch.
            if (sample_cnt == MID_CNT) begin
              sample_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          DATA: begin
            // Sampling one full bit after the mid-start point lands mid-bit.
            if (sample_cnt == LAST_CNT) begin
              shift_reg  <= {rx_s, shift_reg[DATA_BITS-1:1]};
              sample_cnt <= '0;
              bit_cnt    <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          STOP: begin
            // Load at mid stop bit so a back-to-back start edge is not missed.
            if (sample_cnt == LAST_CNT) begin
              state      <= IDLE;
              sample_cnt <= '0;
              RBR        <= shift_reg;
              rx_ready   <= 1'b1;
              frame_err  <= ~rx_s;
              if (rx_ready && !rx_rd) begin
                overrun_err <= 1'b1;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int  OVERSAMPLE = 16;
  localparam int  DATA_BITS  = 8;
  localparam time BCLK_HALF  = 20;                          // bclk period 40 ns
  localparam time BIT_T      = 2 * BCLK_HALF * OVERSAMPLE;  // 640 ns

  logic                 sys_clk;
  logic                 rst;
  logic                 bclk;
  logic                 rx_data;
  logic                 rx_rd;
  logic [DATA_BITS-1:0] RBR;
  logic                 rx_ready;
  logic                 rx_status;
  logic                 frame_err;
  logic                 overrun_err;

  uart_receiver #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .bclk        (bclk),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .RBR         (RBR),
    .rx_ready    (rx_ready),
    .rx_status   (rx_status),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial bclk = 1'b0;
  always #(BCLK_HALF) bclk = ~bclk;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;

  // Counts rising edges of rx_ready, so one-cycle ready pulses are seen.
  int   rises      = 0;
  logic ready_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (rx_ready === 1'b1 && ready_prev === 1'b0) rises++;
    ready_prev = rx_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Serial transmitter model: start, 8 data bits LSB first, stop, one idle bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic rd_in_stop);
    @(negedge sys_clk);
    sb.push_back('{data: d, ferr: ~stop_bit});
    rx_data = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx_data = d[i];
      #(BIT_T);
    end
    rx_data = stop_bit;
    if (rd_in_stop) rx_rd = 1'b1;
    #(BIT_T);
    rx_data = 1'b1;
    rx_rd   = 1'b0;
    #(BIT_T);
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    chk({tag, "_pending"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rbr"}, RBR, e.data);
      chk({tag, "_ferr"}, frame_err, e.ferr);
    end
  endtask

  task automatic pulse_rd();
    @(negedge sys_clk);
    rx_rd = 1'b1;
    @(negedge sys_clk);
    rx_rd = 1'b0;
  endtask

  int r0;
  logic [7:0] lb [3];

  initial begin
    rst     = 1'b1;
    rx_data = 1'b1;
    rx_rd   = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("rst_rbr", RBR, 0);
    chk("rst_ready", rx_ready, 0);
    chk("rst_status", rx_status, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    check_frame("t1");
    chk("t1_ready", rx_ready, 1);
    chk("t1_ovr", overrun_err, 0);
    chk("t1_status", rx_status, 0);
    pulse_rd();
    chk("t1_rd_ready", rx_ready, 0);

    // Short start pulse is rejected at mid-bit
    @(negedge sys_clk);
    rx_data = 1'b0;
    #(4 * 2 * BCLK_HALF);
    chk("t2_status_busy", rx_status, 1);
    rx_data = 1'b1;
    #(BIT_T);
    chk("t2_status_idle", rx_status, 0);
    chk("t2_ready", rx_ready, 0);
    chk("t2_rbr", RBR, 8'hA5);

    // Bad stop bit, then a good frame clears frame_err
    send_frame(8'h3C, 1'b0, 1'b0);
    check_frame("t3a");
    chk("t3a_ready", rx_ready, 1);
    pulse_rd();
    send_frame(8'h55, 1'b1, 1'b0);
    check_frame("t3b");
    pulse_rd();

    // Overrun on second unread frame, cleared by a read
    send_frame(8'h11, 1'b1, 1'b0);
    check_frame("t4a");
    chk("t4a_ovr", overrun_err, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    check_frame("t4b");
    chk("t4b_ovr", overrun_err, 1);
    chk("t4b_ready", rx_ready, 1);
    pulse_rd();
    chk("t4_rd_ready", rx_ready, 0);
    chk("t4_rd_ovr", overrun_err, 0);

    // Reset in the middle of a frame (start + 3 data bits of 0xFF)
    @(negedge sys_clk);
    rx_data = 1'b0;
    #(BIT_T);
    rx_data = 1'b1;
    #(3 * BIT_T);
    chk("t5_busy", rx_status, 1);
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    chk("t5_rbr", RBR, 0);
    chk("t5_ready", rx_ready, 0);
    chk("t5_ferr", frame_err, 0);
    chk("t5_ovr", overrun_err, 0);
    chk("t5_status", rx_status, 0);
    #(2 * BIT_T);
    send_frame(8'h5A, 1'b1, 1'b0);
    check_frame("t5");
    chk("t5_new_ready", rx_ready, 1);

    // Loopback with the read strobe held across each load cycle
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h81;
    for (int k = 0; k < 3; k++) begin
      r0 = rises;
      send_frame(lb[k], 1'b1, 1'b1);
      check_frame($sformatf("t6_%0d", k));
      chk($sformatf("t6_%0d_ovr", k), overrun_err, 0);
      chk($sformatf("t6_%0d_pulse", k), rises - r0, 1);
      chk($sformatf("t6_%0d_ready", k), rx_ready, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
